// File: rtl/gray_pkg.sv
// gray_pkg: shared FSM state encoding and default widths for the Gray step tracker
package gray_pkg;
  localparam int W_DEF    = 3;
  localparam int LAPW_DEF = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, FAULT = 2'd2} state_e;
endpackage

// File: rtl/gray_step_tracker_gray2bin.sv
// gray2bin: combinational Gray-to-binary converter; g_i Gray in, b_o binary out
module gray2bin #(
  parameter int W = 3
) (
  input  logic [W-1:0] g_i,
  output logic [W-1:0] b_o
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign b_o[i] = ^g_i[W-1:i];
  end
endmodule

// File: rtl/gray_step_tracker.sv
// gray_step_tracker: registers decoded Gray input, flags illegal steps, counts laps.
// Ports: Clk, Reset (sync, active-high), Gray, Overflow, Clear in;
// Bin, Step, Wrap, LapCount, LapSat, Error out.
// OVF_CHECK_EN: when defined, an Overflow rise must coincide with every wrap.
module gray_step_tracker
  import gray_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int LAPW = LAPW_DEF
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [W-1:0]    Gray,
  input  logic            Overflow,
  input  logic            Clear,
  output logic [W-1:0]    Bin,
  output logic            Step,
  output logic            Wrap,
  output logic [LAPW-1:0] LapCount,
  output logic            LapSat,
  output logic            Error
);
  state_e state_q, state_d;
  logic [W-1:0] n, bin_q, bin_d;
  logic step_q, step_d, wrap_q, wrap_d;
  logic [LAPW-1:0] lap_q, lap_d;
  logic inc, wrapping, ovf_ok, legal, track_ok;
  gray2bin #(.W(W)) u_g2b (.g_i(Gray), .b_o(n));
  assign inc      = n == bin_q + W'(1);
  assign wrapping = inc && n == '0;
`ifdef OVF_CHECK_EN
  logic ovf_q;
  always_ff @(posedge Clk) ovf_q <= Reset ? 1'b0 : Overflow;
  // A wrap and an Overflow rise must happen on the same sample, or not at all
  assign ovf_ok = wrapping == (Overflow && !ovf_q);
`else
  logic unused_ovf;
  assign unused_ovf = Overflow;
  assign ovf_ok     = 1'b1;
`endif
  assign legal = ovf_ok && (n == bin_q || inc);
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      lap_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      lap_q   <= lap_d;
    end
  end
  always_comb begin
    state_d = Clear ? IDLE :
              state_q == IDLE ? TRACK :
              state_q == TRACK && !legal ? FAULT : state_q;
  end
  always_comb begin
    track_ok = !Clear && state_q == TRACK && legal;
    bin_d    = n;
    step_d   = track_ok && inc;
    wrap_d   = track_ok && wrapping;
    lap_d    = wrap_d && lap_q != '1 ? lap_q + LAPW'(1) : lap_q;
  end
  assign Bin      = bin_q;
  assign Step     = step_q;
  assign Wrap     = wrap_q;
  assign LapCount = lap_q;
  assign LapSat   = lap_q == '1;
  assign Error    = state_q == FAULT;
endmodule

// File: tb/tb_gray_step_tracker.sv
// tb_gray_step_tracker: directed self-checking bench for gray_step_tracker
module tb_gray_step_tracker;
  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [2:0] Gray = 3'b000;
  logic       Overflow = 1'b0;
  logic       Clear = 1'b0;
  logic [2:0] Bin;
  logic       Step, Wrap, LapSat, Error;
  logic [3:0] LapCount;
  int checks = 0;
  int errors = 0;
  logic [2:0] gseq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

  gray_step_tracker dut (
    .Clk(Clk), .Reset(Reset), .Gray(Gray), .Overflow(Overflow), .Clear(Clear),
    .Bin(Bin), .Step(Step), .Wrap(Wrap), .LapCount(LapCount), .LapSat(LapSat), .Error(Error)
  );

  always #5 Clk = ~Clk;

  task automatic tick(input logic [2:0] g, input logic ov);
    Gray = g;
    Overflow = ov;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick(3'b000, 1'b0);
    Reset = 1'b0;
  endtask

  // One full lap from binary 0 back to 0, Overflow raised on the wrap sample
  task automatic run_lap(input int exp_lap);
    for (int k = 1; k <= 8; k++) begin
      tick(gseq[k % 8], k == 8);
      checks++;
      if ({Bin, Step, Wrap, Error} !== {3'(k % 8), 1'b1, k == 8, 1'b0}) begin
        errors++;
        $display("FAIL lap_step k=%0d: Bin=%0d Step=%b Wrap=%b Error=%b, want Bin=%0d Step=1 Wrap=%b Error=0",
                 k, Bin, Step, Wrap, Error, k % 8, k == 8);
      end
    end
    checks++;
    if ({LapCount, LapSat} !== {4'(exp_lap), exp_lap == 15}) begin
      errors++;
      $display("FAIL lap_count: LapCount=%0d LapSat=%b, want %0d %b", LapCount, LapSat, exp_lap, exp_lap == 15);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick(3'b101, 1'b1);
    checks++;
    if ({Bin, Step, Wrap, LapCount, LapSat, Error} !== 10'd0) begin
      errors++;
      $display("FAIL reset: Bin=%0d Step=%b Wrap=%b LapCount=%0d LapSat=%b Error=%b, want all 0",
               Bin, Step, Wrap, LapCount, LapSat, Error);
    end
    Reset = 1'b0;
  endtask

  task automatic test_lap();
    tick(3'b000, 1'b0);
    checks++;
    if ({Bin, Step, Wrap, Error} !== 6'd0) begin
      errors++;
      $display("FAIL idle_capture: Bin=%0d Step=%b Wrap=%b Error=%b, want 0 0 0 0", Bin, Step, Wrap, Error);
    end
    run_lap(1);
  endtask

  task automatic test_hold();
    tick(3'b001, 1'b0);
    tick(3'b011, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(3'b011, 1'b0);
      checks++;
      if ({Bin, Step, Wrap, Error} !== {3'd2, 3'b000}) begin
        errors++;
        $display("FAIL hold: Bin=%0d Step=%b Wrap=%b Error=%b, want Bin=2 Step=0 Wrap=0 Error=0", Bin, Step, Wrap, Error);
      end
    end
  endtask

  task automatic test_fault_clear();
    do_reset();
    tick(3'b000, 1'b0);
    run_lap(1);
    run_lap(2);
    run_lap(3);
    tick(3'b001, 1'b0);
    tick(3'b111, 1'b0);
    checks++;
    if ({Bin, Step, Error} !== {3'd5, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL jump_fault: Bin=%0d Step=%b Error=%b, want Bin=5 Step=0 Error=1", Bin, Step, Error);
    end
    tick(3'b101, 1'b0);
    checks++;
    if ({Bin, Step, Error, LapCount} !== {3'd6, 1'b0, 1'b1, 4'd3}) begin
      errors++;
      $display("FAIL fault_sticky: Bin=%0d Step=%b Error=%b LapCount=%0d, want 6 0 1 3", Bin, Step, Error, LapCount);
    end
    Clear = 1'b1;
    tick(3'b101, 1'b0);
    Clear = 1'b0;
    checks++;
    if ({Error, LapCount} !== {1'b0, 4'd3}) begin
      errors++;
      $display("FAIL clear: Error=%b LapCount=%0d, want Error=0 LapCount=3", Error, LapCount);
    end
    tick(3'b110, 1'b0);
    checks++;
    if ({Bin, Step, Error, LapCount} !== {3'd4, 1'b0, 1'b0, 4'd3}) begin
      errors++;
      $display("FAIL post_clear_idle: Bin=%0d Step=%b Error=%b LapCount=%0d, want 4 0 0 3", Bin, Step, Error, LapCount);
    end
    tick(3'b111, 1'b0);
    checks++;
    if ({Bin, Step, Error} !== {3'd5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL post_clear_track: Bin=%0d Step=%b Error=%b, want 5 1 0", Bin, Step, Error);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    tick(3'b000, 1'b0);
    for (int l = 1; l <= 16; l++) run_lap(l > 15 ? 15 : l);
    run_lap(15);
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(3'b000, 1'b0);
    run_lap(1);
    run_lap(2);
    for (int k = 1; k <= 5; k++) tick(gseq[k], 1'b0);
    checks++;
    if ({Bin, LapCount, Error} !== {3'd5, 4'd2, 1'b0}) begin
      errors++;
      $display("FAIL mid_lap: Bin=%0d LapCount=%0d Error=%b, want 5 2 0", Bin, LapCount, Error);
    end
    Reset = 1'b1;
    Clear = 1'b1;
    tick(3'b111, 1'b0);
    Reset = 1'b0;
    Clear = 1'b0;
    checks++;
    if ({Bin, Step, Wrap, LapCount, LapSat, Error} !== 10'd0) begin
      errors++;
      $display("FAIL reset_mid: Bin=%0d Step=%b Wrap=%b LapCount=%0d LapSat=%b Error=%b, want all 0",
               Bin, Step, Wrap, LapCount, LapSat, Error);
    end
    tick(3'b010, 1'b0);
    checks++;
    if ({Bin, Step, Error} !== {3'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_idle: Bin=%0d Step=%b Error=%b, want 3 0 0", Bin, Step, Error);
    end
    tick(3'b110, 1'b0);
    checks++;
    if ({Bin, Step, Error} !== {3'd4, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_track: Bin=%0d Step=%b Error=%b, want 4 1 0", Bin, Step, Error);
    end
  endtask

  task automatic test_overflow();
`ifdef OVF_CHECK_EN
    do_reset();
    for (int k = 0; k < 8; k++) tick(gseq[k], 1'b0);
    tick(3'b000, 1'b0);
    checks++;
    if ({Error, Wrap, LapCount} !== {1'b1, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL ovf_missing: Error=%b Wrap=%b LapCount=%0d, want 1 0 0", Error, Wrap, LapCount);
    end
    do_reset();
    for (int k = 0; k < 8; k++) tick(gseq[k], 1'b0);
    tick(3'b000, 1'b1);
    checks++;
    if ({Error, Wrap, LapCount} !== {1'b0, 1'b1, 4'd1}) begin
      errors++;
      $display("FAIL ovf_wrap: Error=%b Wrap=%b LapCount=%0d, want 0 1 1", Error, Wrap, LapCount);
    end
    tick(3'b000, 1'b0);
    tick(3'b001, 1'b1);
    checks++;
    if (Error !== 1'b1) begin
      errors++;
      $display("FAIL ovf_spurious: Error=%b, want 1", Error);
    end
`else
    do_reset();
    tick(3'b000, 1'b0);
    tick(3'b001, 1'b1);
    checks++;
    if ({Bin, Step, Error} !== {3'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ovf_ignored: Bin=%0d Step=%b Error=%b, want 1 1 0", Bin, Step, Error);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_lap();
    test_hold();
    test_fault_clear();
    test_saturation();
    test_reset_mid();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gray_step_tracker.md
Name: gray_step_tracker

Overview:
- Downstream consumer of the 3-bit Gray counter stage (Output/Overflow pair).
- Samples the Gray code every clock and registers its binary equivalent.
- Checks that every change is a legal single-bit increment, flags illegal transitions, and counts completed laps (wrap from max to 0).
- Feeds status and lap count to the following display/compare stage.

Parameters:
- W, 3, Gray/binary code width.
- LAPW, 4, lap counter width.

Ports:
- Clk  input  1  system clock, all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Gray  input  W  Gray code from the upstream counter.
- Overflow  input  1  overflow flag from the upstream counter.
- Clear  input  1  synchronous fault clear (returns FSM to IDLE, keeps LapCount).
- Bin  output  W  registered binary value of the last sampled Gray.
- Step  output  1  one-cycle pulse: the last sample was a legal +1 step.
- Wrap  output  1  one-cycle pulse: the last step was 2^W-1 -> 0.
- LapCount  output  LAPW  number of wraps since reset, saturating.
- LapSat  output  1  high while LapCount is at its maximum.
- Error  output  1  sticky, high while the FSM is in FAULT.

Behaviour:
- Reset: when Reset=1 at a rising edge, the next values are
  - Bin=0, Step=0, Wrap=0, LapCount=0, LapSat=0, Error=0;
  - the previous-sample register is cleared to 0;
  - FSM=IDLE.
- Reset has priority over Clear and all other events, including mid-lap and in FAULT.
- Decode: bin[W-1]=g[W-1]; bin[i]=bin[i+1]^g[i] for i=W-2 down to 0. Purely combinational from Gray, then registered.
- Latency: Bin, Step and Wrap reflect the Gray value sampled one cycle earlier.
- FSM states: IDLE, TRACK, FAULT.
- IDLE:
  - The first edge after reset or Clear captures Gray into Bin and the previous-sample register.
  - Step=0 and Wrap=0; any value is accepted.
  - Next state is TRACK.
- TRACK, with p = previous decoded value and n = current decoded value:
  - n==p: hold; Step=0, Wrap=0.
  - n==(p+1) mod 2^W: Step=1. If p==2^W-1 and n==0, Wrap=1 and LapCount increments, saturating at 2^LAPW-1.
  - Any other n, including multi-bit jumps and backwards steps: go to FAULT; Error=1; Bin still updates to n; Step=0; no lap count change.
- FAULT:
  - Bin keeps tracking the decoded input.
  - Step=0 and Wrap=0; LapCount frozen; Error=1.
  - Stays in FAULT until Reset or Clear.
- Clear=1 (without Reset):
  - FSM goes to IDLE and Error goes to 0 on the next edge.
  - LapCount and LapSat are kept.
  - Clear in TRACK also re-arms through IDLE, so the next sample is unchecked.
- Held input: an upstream enable low gives a constant Gray, which is legal and produces no pulses.
- LapSat = (LapCount == 2^LAPW-1). At saturation a further wrap still pulses Wrap; the count does not roll over.
- Without the optional feature, Overflow is ignored.

Optional Feature:
- Macro: OVF_CHECK_EN.
- Defined:
  - Overflow is registered each cycle.
  - In TRACK, a rising edge of Overflow must coincide with the sample on which Wrap is asserted.
  - A Wrap without an Overflow rise, or an Overflow rise without a Wrap, is treated as an illegal transition (go to FAULT, Error=1).
- Not defined: the Overflow input is unused and no Overflow register is built.

Decomposition:
- Shared package gray_pkg holds:
  - the FSM state encoding (IDLE=2'd0, TRACK=2'd1, FAULT=2'd2);
  - the default widths W=3 and LAPW=4.
- One sub-module: gray2bin, a parameterised combinational Gray-to-binary converter, instantiated once.

Test Plan:
- Reset then Gray sequence 000,001,011,010,110,111,101,100,000 on successive edges.
  - Bin follows 0..7,0 one cycle late.
  - Step is high for 8 cycles.
  - Wrap pulses once; LapCount=1; Error=0.
- Hold Gray=011 for 5 cycles in TRACK: Bin=2, Step=0, no Error.
- From Gray=001, apply 111: Error=1 next cycle, Bin=5, Step=0. Then apply the legal step 101: Step stays 0 and Error stays 1.
- In FAULT with LapCount=3, pulse Clear for one cycle:
  - Error=0 and the FSM goes to IDLE;
  - the next sample (any value, e.g. 110) is accepted;
  - LapCount stays 3.
- Run 16 full laps: LapCount=15 and LapSat=1. A 17th wrap pulses Wrap and LapCount stays 15.
- Reset=1 mid-lap (Bin=5, LapCount=2): next cycle all outputs are 0 and the FSM is IDLE.
- With OVF_CHECK_EN: a legal 100->000 wrap with Overflow held low gives Error=1. The same wrap with an Overflow rise gives LapCount+1 and no Error.
